// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with start/busy/done handshake.
// The result registers only change on the last shift iteration, so a display never sees partial values.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [BIN_W-1:0]    bin_in,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic [3:0]          sig_digits,
    output logic                overflow,
    output logic [1:0]          fsm_state
);

    localparam int SW    = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W) + 1;

    // Handshake: a conversion is accepted on any rising edge where start=1 and busy=0
    // (IDLE or FINISH); busy is high exactly in SHIFT; done is high exactly in FINISH.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t state, state_next;

    logic [BIN_W-1:0] bin_reg;
    logic [SW-1:0]    scratch, adj, scratch_next;
    logic [CNT_W-1:0] iter;
    logic             ovf_sticky, shift_out, top_wrap, final_ovf;
    logic             last_iter, accept;
    logic [3:0]       sig_next;

    assign last_iter = (iter == CNT_W'(BIN_W - 1));
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_iter) state_next = FINISH;
            end
            FINISH: begin
                done = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Add-3 correction on every nibble, then one left shift of {scratch, bin_reg}.
    always_comb begin
        adj = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
    end

    // A top nibble of 13..15 would wrap during correction; treat that as overflow too.
    assign top_wrap     = (scratch[SW-1 -: 4] >= 4'd13);
    assign shift_out    = adj[SW-1];
    assign scratch_next = {adj[SW-2:0], bin_reg[BIN_W-1]};
    assign final_ovf    = ovf_sticky | shift_out | top_wrap | (scratch_next[SW-1 -: 4] > 4'd9);

    always_comb begin
        sig_next = 4'd1;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_next[4*i +: 4] != 4'd0) sig_next = 4'(i + 1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bin_reg    <= '0;
            scratch    <= '0;
            iter       <= '0;
            ovf_sticky <= 1'b0;
            bcd_out    <= '0;
            sig_digits <= 4'd1;
            overflow   <= 1'b0;
        end else if (accept) begin
            bin_reg    <= bin_in;
            scratch    <= '0;
            iter       <= '0;
            ovf_sticky <= 1'b0;
        end else if (state == SHIFT) begin
            bin_reg    <= bin_reg << 1;
            scratch    <= scratch_next;
            iter       <= iter + 1'b1;
            ovf_sticky <= ovf_sticky | shift_out | top_wrap;
            if (last_iter) begin
                bcd_out    <= scratch_next;
                sig_digits <= sig_next;
                overflow   <= final_ovf;
            end
        end
    end

endmodule
